// File: rtl/prim_reqack_src_buffer.sv
// Source-side front end for the REQ/ACK synchronizer: a small FIFO whose head word
// is held on data_o under a registered, pulse-ACK REQ with an optional REQ-low gap.
module prim_reqack_src_buffer #(
  parameter int unsigned Width     = 8,
  parameter int unsigned Depth     = 4,
  parameter int unsigned GapCycles = 0,
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             req_o,
  input  logic             ack_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             err_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned GapW = (GapCycles > 0) ? $clog2(GapCycles + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]  r_count, w_count_nxt;
  logic             r_err;
  logic [Width-1:0] r_mem [Depth];
  logic             w_push, w_pop, w_gap_load, w_gap_done;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A pop never frees a slot for a push in the same cycle.
  assign in_ready_o = rst_ni & (r_count < CntW'(Depth));
  assign w_push     = in_valid_i & in_ready_o;
  assign req_o      = (r_state == ST_REQ);
  assign w_pop      = req_o & ack_i;
  assign data_o     = r_mem[r_rd_ptr];
  assign count_o    = r_count;
  assign err_o      = r_err;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CntW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gap_load  = 1'b0;
    case (r_state)
      ST_IDLE: if (r_count != '0) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (ack_i) begin
          if (GapCycles > 0) begin
            w_state_nxt = ST_GAP;
            w_gap_load  = 1'b1;
          end else begin
            w_state_nxt = (w_count_nxt != '0) ? ST_REQ : ST_IDLE;
          end
        end
      end
      ST_GAP: if (w_gap_done) w_state_nxt = (r_count != '0) ? ST_REQ : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (ack_i && !req_o) r_err <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data_i;
  end

  if (GapCycles > 0) begin : g_gap
    logic [GapW-1:0] r_gap_cnt;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        r_gap_cnt <= '0;
      end else if (w_gap_load) begin
        r_gap_cnt <= GapW'(GapCycles - 1);
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - GapW'(1);
      end
    end
    assign w_gap_done = (r_gap_cnt == '0);
  end else begin : g_no_gap
    logic unused_gap_load;
    assign unused_gap_load = w_gap_load;
    assign w_gap_done      = 1'b1;
  end

endmodule

// File: tb/tb_prim_reqack_src_buffer.sv
// Bench for prim_reqack_src_buffer: two lanes (GapCycles 0 and 3), directed scenarios
// then random traffic, all checked every cycle against a queue-based model.
module tb_prim_reqack_src_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  for (genvar L = 0; L < 2; L++) begin : g_lane
    localparam int G = (L == 0) ? 0 : 3;
    logic       rst_n, vld, ack;
    logic [7:0] din;
    logic       rdy, req, err;
    logic [7:0] dout;
    logic [2:0] cnt;
    bit         done = 1'b0;

    prim_reqack_src_buffer #(.Width(8), .Depth(4), .GapCycles(G)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(vld), .in_ready_o(rdy), .in_data_i(din),
      .req_o(req), .ack_i(ack), .data_o(dout), .count_o(cnt), .err_o(err)
    );

    // Model: queue of words, REQ flag, cycles of enforced REQ-low left, sticky error.
    byte unsigned q[$];
    bit m_req  = 1'b0;
    int m_hold = 0;
    bit m_err  = 1'b0;
    bit m_push, m_pop, m_nreq;

    always @(posedge clk) begin
      if (!rst_n) begin
        q.delete();
        m_req = 0; m_hold = 0; m_err = 0;
      end else begin
        m_push = vld && (q.size() < 4);
        m_pop  = m_req && ack;
        if (ack && !m_req) m_err = 1;
        m_nreq = 0;
        if (m_req) begin
          if (!ack)        m_nreq = 1;
          else if (G == 0) m_nreq = (q.size() - 1 + int'(m_push)) != 0;
          else             m_hold = G;
        end else if (m_hold > 1) begin
          m_hold--;
        end else begin
          m_hold = 0;
          m_nreq = q.size() != 0;
        end
        if (m_pop)  void'(q.pop_front());
        if (m_push) q.push_back(din);
        m_req = m_nreq;
      end
    end

    // One cycle: check outputs at the falling edge, then drive the next inputs.
    // am: 0 no ACK, 1 ACK whenever REQ is up, 2 ACK unconditionally.
    task automatic cyc(input bit r, input bit v, input logic [7:0] d, input int am);
      @(negedge clk);
      chk_eq($sformatf("L%0d req", L), 32'(req), 32'(m_req));
      chk_eq($sformatf("L%0d count", L), 32'(cnt), q.size());
      chk_eq($sformatf("L%0d ready", L), 32'(rdy), 32'(rst_n && (q.size() < 4)));
      chk_eq($sformatf("L%0d err", L), 32'(err), 32'(m_err));
      if (m_req) chk_eq($sformatf("L%0d data", L), 32'(dout), 32'(q[0]));
      rst_n = r;
      vld   = v;
      din   = d;
      ack   = (am == 2) || (am == 1 && m_req);
    endtask

    initial begin
      int ph, vp, ap, am;
      rst_n = 1'b0; vld = 1'b0; ack = 1'b0; din = 8'h00;
      cyc(0, 0, 8'h00, 0);
      // Single word, ACKed on the first REQ cycle.
      cyc(1, 1, 8'hA5, 0);
      repeat (6) cyc(1, 0, 8'h00, 1);
      // Fill to full with a fifth word held off, then drain with ACK every REQ cycle.
      for (int i = 1; i <= 5; i++) cyc(1, 1, 8'(i), 0);
      repeat (3) cyc(1, 0, 8'h00, 0);
      repeat (20) cyc(1, 0, 8'h00, 1);
      // Pointer wrap: another four words.
      for (int i = 5; i <= 8; i++) cyc(1, 1, 8'(i), 1);
      repeat (20) cyc(1, 0, 8'h00, 1);
      // Two queued, ACK with a push alongside.
      cyc(1, 1, 8'h11, 0); cyc(1, 1, 8'h22, 0); cyc(1, 0, 8'h00, 0);
      cyc(1, 1, 8'h77, 1);
      repeat (20) cyc(1, 0, 8'h00, 1);
      // Spurious ACK while idle and empty; error must stick until reset.
      cyc(1, 0, 8'h00, 2);
      repeat (5) cyc(1, 0, 8'h00, 0);
      // Reset while REQ is up with three words queued.
      cyc(1, 1, 8'h31, 0); cyc(1, 1, 8'h32, 0); cyc(1, 1, 8'h33, 0);
      repeat (2) cyc(1, 0, 8'h00, 0);
      cyc(0, 0, 8'h00, 0);
      cyc(1, 0, 8'h00, 0);
      repeat (4) cyc(1, 0, 8'h00, 0);
      // Random traffic in phases of varying push and ACK density.
      for (int i = 0; i < 3000; i++) begin
        ph = (i / 250) % 4;
        vp = (ph == 0) ? 4 : (ph == 1) ? 1 : (ph == 2) ? 3 : 2;
        ap = (ph == 0) ? 1 : (ph == 1) ? 4 : (ph == 2) ? 2 : 3;
        if ($urandom_range(0, 199) == 0) am = 2;
        else am = ($urandom_range(0, 3) < ap) ? 1 : 0;
        cyc($urandom_range(0, 399) != 0, $urandom_range(0, 3) < vp, 8'($urandom), am);
      end
      cyc(1, 0, 8'h00, 0);
      done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: lanes done %0b%0b expected 11", g_lane[1].done, g_lane[0].done);
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait (g_lane[0].done && g_lane[1].done);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/prim_reqack_src_buffer.md
# prim_reqack_src_buffer

Single-clock source-side front end for the REQ/ACK data synchronizer. It accepts words from a valid/ready stream, buffers them in a small FIFO, and presents the head word on a pulse-ACK REQ/ACK port. `req_o` stays asserted and `data_o` stays stable from REQ assertion until the handshake completes. It sits in the SRC clock domain, directly upstream of the synchronizer, and drives its `src_req_i` and `data_i` from its own `req_o` and `data_o`.

## Interface
- `Width`, default 8: data width in bits, ≥1.
- `Depth`, default 4: FIFO entries, ≥1; need not be a power of two.
- `GapCycles`, default 0: minimum number of cycles `req_o` is held low after each completed handshake; 0 allows back-to-back REQs.
- `CntW`, default `$clog2(Depth+1)`: localparam, occupancy width.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset. One clock; reset is synchronous and active-low.
- `in_valid_i`, input, 1: upstream word valid.
- `in_ready_o`, output, 1: buffer can accept a word.
- `in_data_i`, input, Width: upstream word.
- `req_o`, output, 1: REQ to the synchronizer SRC side. Registered.
- `ack_i`, input, 1: single-cycle ACK pulse from the synchronizer SRC side.
- `data_o`, output, Width: head FIFO entry.
- `count_o`, output, CntW: current FIFO occupancy.
- `err_o`, output, 1: sticky protocol error.

## Operation
- **Push** when `in_valid_i & in_ready_o`.
- **`in_ready_o`** = `rst_ni & (count < Depth)`.
  - Pops are not forwarded combinationally. A full buffer never accepts a word, even in a cycle where a pop occurs.
- **Pop** when `req_o & ack_i`.
  - Read pointer advances by 1 and wraps from Depth-1 to 0.
  - Write pointer wraps the same way.
- **Occupancy**: `count` += push − pop. Simultaneous push and pop leaves it unchanged.
- **`data_o`** = `mem[rd_ptr]`, read from the storage array.
  - Only the read pointer selects it; `rd_ptr` moves only on a pop, so `data_o` is stable for the whole REQ phase.
  - `data_o` is undefined-but-stable when the FIFO is empty.
- **FSM states**: IDLE (`req_o`=0), REQ (`req_o`=1), GAP (`req_o`=0).
  - IDLE → REQ when count ≠ 0.
  - REQ stays in REQ while `ack_i`=0.
  - REQ on `ack_i`=1, with GapCycles=0: go to REQ if count after the pop ≠ 0, else IDLE.
  - REQ on `ack_i`=1, with GapCycles>0: go to GAP and load `gap_cnt` = GapCycles−1.
  - GAP with `gap_cnt` ≠ 0: decrement `gap_cnt`.
  - GAP with `gap_cnt` = 0: go to REQ if count ≠ 0, else IDLE.
  - `gap_cnt` is `$clog2(GapCycles+1)` bits wide, minimum 1. It is absent from the logic when GapCycles=0.
- **`err_o`** sets when `ack_i`=1 while `req_o`=0. It holds until reset and has no other effect; a spurious ACK never pops.

## Timing
- **Reset** (rising edge with `rst_ni`=0):
  - Outputs: `req_o`=0, `count_o`=0, `err_o`=0.
  - Internal: FSM=IDLE, pointers=0, `gap_cnt`=0.
  - `in_ready_o`=0 combinationally while `rst_ni`=0, and 1 in the first cycle after reset.
  - Storage contents are not reset.
- **Reset mid-handshake**: state is dropped. `req_o` is 0 from the cycle after the reset edge, and buffered words are discarded.
- **Latency, empty buffer**: a word accepted in cycle t gives `count_o`=1 in t+1 and `req_o`=1 in t+2, with `data_o` = that word.
- **Back-to-back, GapCycles=0**: ACK in cycle k.
  - `req_o` stays 1 through k+1 if words remain, and `data_o` shows the next word from k+1.
  - If the FIFO empties, `req_o`=0 in k+1.
- **GapCycles=G>0**: ACK in cycle k.
  - `req_o`=0 in cycles k+1 … k+G.
  - `req_o`=1 in k+G+1 if count ≠ 0 at the end of k+G.
- **Full buffer**: `in_ready_o`=0 while count=Depth. It returns to 1 in the cycle after the pop.
- **ACK timing**: ACK is accepted in any REQ cycle, including the first cycle REQ is asserted.

## Test plan
- **Single word**: Depth=4, G=0; push 0xA5 at t=0; ACK in the cycle `req_o` first rises (t+2). Expect `req_o`=1 at t+2 and 0 at t+3, `data_o`=0xA5 during REQ, `count_o` back to 0.
- **Fill and back-to-back drain**: push 0x01..0x04 on consecutive cycles; 5th push held. Expect `in_ready_o`=0 at count=4. ACK every REQ cycle; `data_o` sequence 01,02,03,04 with `req_o` continuously high; pointer wrap verified by pushing 0x05..0x08 afterwards.
- **Gap**: G=3; two words queued; ACK first REQ at cycle k. Expect `req_o` low in k+1..k+3 and high in k+4 with the second word.
- **Simultaneous push/pop**: count=2, push 0x77 in the same cycle as the ACK. Expect `count_o` to stay 2 and 0x77 to reach `data_o` after the remaining word.
- **Spurious ACK**: ACK while idle and empty. Expect `err_o`=1 from the next cycle, `count_o` unchanged, and `err_o` cleared only by reset.
- **Reset during REQ**: 3 words queued, REQ high, `rst_ni`=0 for one edge. Expect `req_o`=0, `count_o`=0, `err_o`=0 afterwards and `in_ready_o`=0 while reset is held.
